vreg_file: RTL and testbench

- Parametrised vector register file for the SIMD datapath; successor to the fixed 4x256-bit, two-read-port file.
- Runs on one clock with configurable entry count, vector width and read-port count.
- Adds byte-masked writes, same-cycle write-to-read bypass, a per-register pending-write scoreboard, and a sequenced hardware clear.
- Sits between decode (reads, reservations) and writeback (writes).

---
 rtl/vreg_pkg.sv | 28 ++
 rtl/vreg_file_if.sv | 40 ++++
 rtl/vreg_read_port.sv | 72 +++++++
 rtl/vreg_file.sv | 131 +++++++++++++
 tb/tb_vreg_file.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/vreg_pkg.sv
// Shared types, constants and the byte-merge helper for the vector register file.
package vreg_pkg;

  localparam int ADDR_W   = 5;
  // Widest vector the merge helper handles; callers cast in and out of it.
  localparam int MAX_VLEN = 2048;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // Byte lanes with mask=1 take new_d, all other lanes keep old_d.
  function automatic logic [MAX_VLEN-1:0] merge_bytes(
    input logic [MAX_VLEN-1:0]   old_d,
    input logic [MAX_VLEN-1:0]   new_d,
    input logic [MAX_VLEN/8-1:0] mask
  );
    logic [MAX_VLEN-1:0] res;
    res = old_d;
    for (int b = 0; b < MAX_VLEN/8; b++) begin
      if (mask[b]) res[8*b +: 8] = new_d[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vreg_file_if.sv
// Decode/writeback bus of the vector register file.
//
// Handshake: RE[i] is a request sampled at the clock edge; RVALID[i] is high
// for exactly the cycle after an accepted request, with RD[i]/RBUSY[i]
// valid alongside it. There is no backpressure: every request is accepted.
// WE, RSV_EN and CLR_REQ are single-cycle commands sampled at the edge;
// CLR_BUSY stays high while a clear runs and CLR_DONE pulses once at its end.
interface vreg_file_if
  import vreg_pkg::*;
#(
  parameter int VLEN = 256,
  parameter int NRD  = 2
);

  logic [NRD-1:0]        RE;
  logic [NRD*ADDR_W-1:0] RA;
  logic [NRD*VLEN-1:0]   RD;
  logic [NRD-1:0]        RVALID;
  logic [NRD-1:0]        RBUSY;
  logic                  WE;
  logic [ADDR_W-1:0]     WA;
  logic [VLEN/8-1:0]     WMASK;
  logic [VLEN-1:0]       WD;
  logic                  RSV_EN;
  logic [ADDR_W-1:0]     RSV_A;
  logic                  CLR_REQ;
  logic                  CLR_BUSY;
  logic                  CLR_DONE;

  modport master (
    output RE, RA, WE, WA, WMASK, WD, RSV_EN, RSV_A, CLR_REQ,
    input  RD, RVALID, RBUSY, CLR_BUSY, CLR_DONE
  );

  modport slave (
    input  RE, RA, WE, WA, WMASK, WD, RSV_EN, RSV_A, CLR_REQ,
    output RD, RVALID, RBUSY, CLR_BUSY, CLR_DONE
  );

endinterface

// File: rtl/vreg_read_port.sv
// One read port: range check, same-cycle write/reserve bypass, output regs.
module vreg_read_port
  import vreg_pkg::*;
#(
  parameter int VLEN  = 256,
  parameter int NREGS = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  input  logic [VLEN-1:0]   regs [NREGS],
  input  logic [NREGS-1:0]  rsv,
  input  logic              clr_busy,
  input  logic              we_eff,
  input  logic [ADDR_W-1:0] wa,
  input  logic [VLEN/8-1:0] wmask,
  input  logic [VLEN-1:0]   wd,
  input  logic              rsv_set,
  input  logic [ADDR_W-1:0] rsv_a,
  output logic [VLEN-1:0]   rd,
  output logic              rvalid,
  output logic              rbusy
);

  localparam int IDXW     = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int MAX_MASK = MAX_VLEN / 8;

  logic            in_range;
  logic            wr_hit;
  logic            rsv_hit;
  logic [IDXW-1:0] idx;
  logic [VLEN-1:0] rd_nxt;
  logic            rbusy_nxt;

  // Post-edge view of the addressed register: merged write data and the
  // reservation state after this edge's write/reserve (reserve wins).
  always_comb begin
    rd_nxt    = '0;
    rbusy_nxt = 1'b0;
    in_range  = ({1'b0, ra} < (ADDR_W+1)'(NREGS));
    idx       = ra[IDXW-1:0];
    wr_hit    = we_eff && (wa == ra);
    rsv_hit   = rsv_set && (rsv_a == ra);
    if (in_range && !clr_busy) begin
      if (wr_hit) begin
        rd_nxt = VLEN'(merge_bytes(MAX_VLEN'(regs[idx]), MAX_VLEN'(wd), MAX_MASK'(wmask)));
      end else begin
        rd_nxt = regs[idx];
      end
      if (rsv_hit)     rbusy_nxt = 1'b1;
      else if (wr_hit) rbusy_nxt = 1'b0;
      else             rbusy_nxt = rsv[idx];
    end
  end

  // Output registers: data and busy hold when no read is requested.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd     <= '0;
      rvalid <= 1'b0;
      rbusy  <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        rd    <= rd_nxt;
        rbusy <= rbusy_nxt;
      end
    end
  end

endmodule

// File: rtl/vreg_file.sv
// Parametrised vector register file: storage, pending-write reservations,
// sequenced clear, and NRD bypassing read ports.
module vreg_file
  import vreg_pkg::*;
#(
  parameter int VLEN  = 256,
  parameter int NREGS = 8,
  parameter int NRD   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  vreg_file_if.slave  bus,
  output clr_state_t  dbg_state
);

  localparam int IDXW     = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int MAX_MASK = MAX_VLEN / 8;

  logic [VLEN-1:0]     regs [NREGS];
  logic [NREGS-1:0]    rsv;
  clr_state_t          state, state_nxt;
  logic [IDXW-1:0]     cnt, cnt_nxt;
  logic                clr_done_q, clr_done_nxt;
  logic                clr_busy, clr_start;
  logic                wa_ok, rsv_a_ok, we_eff, rsv_set;
  logic [IDXW-1:0]     widx, rsv_idx;
  logic [VLEN-1:0]     wmerged;
  logic [NRD*VLEN-1:0] rd_flat;
  logic [NRD-1:0]      rvalid_v, rbusy_v;

  assign clr_busy  = (state != IDLE);
  assign clr_start = (state == IDLE) && bus.CLR_REQ;
  assign wa_ok     = ({1'b0, bus.WA} < (ADDR_W+1)'(NREGS));
  assign rsv_a_ok  = ({1'b0, bus.RSV_A} < (ADDR_W+1)'(NREGS));
  assign widx      = bus.WA[IDXW-1:0];
  assign rsv_idx   = bus.RSV_A[IDXW-1:0];
  assign we_eff    = bus.WE && !clr_busy && wa_ok;
  // A clear starting this edge wipes all reservations, so a reserve is moot.
  assign rsv_set   = bus.RSV_EN && !clr_busy && !clr_start && rsv_a_ok;
  assign wmerged   = VLEN'(merge_bytes(MAX_VLEN'(regs[widx]), MAX_VLEN'(bus.WD),
                                       MAX_MASK'(bus.WMASK)));

  // Clear FSM state, sweep counter and the registered done pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      clr_done_q <= clr_done_nxt;
    end
  end

  // Clear FSM next state: sweep every register once, then a DONE cycle.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    clr_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (bus.CLR_REQ) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (cnt == IDXW'(NREGS-1)) state_nxt = DONE;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      DONE: begin
        state_nxt    = IDLE;
        clr_done_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage: the clear sweep owns the array while it runs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else if (we_eff) begin
      regs[widx] <= wmerged;
    end
  end

  // Reservations: a write retires its register, a same-edge reserve wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rsv <= '0;
    end else if (clr_start) begin
      rsv <= '0;
    end else begin
      if (we_eff)  rsv[widx]    <= 1'b0;
      if (rsv_set) rsv[rsv_idx] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    vreg_read_port #(.VLEN(VLEN), .NREGS(NREGS)) u_port (
      .CLK      (CLK),
      .RST      (RST),
      .re       (bus.RE[i]),
      .ra       (bus.RA[ADDR_W*i +: ADDR_W]),
      .regs     (regs),
      .rsv      (rsv),
      .clr_busy (clr_busy),
      .we_eff   (we_eff),
      .wa       (bus.WA),
      .wmask    (bus.WMASK),
      .wd       (bus.WD),
      .rsv_set  (rsv_set),
      .rsv_a    (bus.RSV_A),
      .rd       (rd_flat[VLEN*i +: VLEN]),
      .rvalid   (rvalid_v[i]),
      .rbusy    (rbusy_v[i])
    );
  end

  assign bus.RD       = rd_flat;
  assign bus.RVALID   = rvalid_v;
  assign bus.RBUSY    = rbusy_v;
  assign bus.CLR_BUSY = clr_busy;
  assign bus.CLR_DONE = clr_done_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_vreg_file.sv
// Directed bench for vreg_file with an expected-queue scoreboard per read port.
module tb_vreg_file;
  import vreg_pkg::*;

  localparam int VLEN  = 256;
  localparam int NREGS = 8;
  localparam int NRD   = 2;
  localparam int W     = VLEN + 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  clr_state_t dbg_state;

  vreg_file_if #(.VLEN(VLEN), .NRD(NRD)) bus ();

  vreg_file #(.VLEN(VLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_port(input int p, input logic [VLEN-1:0] d, input logic b);
    logic [W-1:0] e;
    if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL port%0d_unexpected_rvalid: got rvalid=1 expected no read pending", p);
    end else begin
      e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("port%0d_rd", p),    W'(d), W'(e[VLEN-1:0]));
      check($sformatf("port%0d_rbusy", p), W'(b), W'(e[VLEN]));
    end
  endtask

  // Monitor: outputs settle after the rising edge, sample on the falling one.
  always @(negedge CLK) begin
    if (RST) begin
      if (bus.RVALID[0]) mon_port(0, bus.RD[0 +: VLEN], bus.RBUSY[0]);
      if (bus.RVALID[1]) mon_port(1, bus.RD[VLEN +: VLEN], bus.RBUSY[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
    bus.RE      = '0;
    bus.WE      = 1'b0;
    bus.RSV_EN  = 1'b0;
    bus.CLR_REQ = 1'b0;
  endtask

  task automatic set_read(input int p, input logic [4:0] a,
                          input logic [VLEN-1:0] exp_d, input logic exp_b);
    bus.RE[p]         = 1'b1;
    bus.RA[5*p +: 5]  = a;
    if (p == 0) exp_q0.push_back({exp_b, exp_d});
    else        exp_q1.push_back({exp_b, exp_d});
  endtask

  task automatic set_write(input logic [4:0] a, input logic [VLEN/8-1:0] m,
                           input logic [VLEN-1:0] d);
    bus.WE    = 1'b1;
    bus.WA    = a;
    bus.WMASK = m;
    bus.WD    = d;
  endtask

  task automatic set_rsv(input logic [4:0] a);
    bus.RSV_EN = 1'b1;
    bus.RSV_A  = a;
  endtask

  function automatic logic [VLEN-1:0] pat(input int r);
    logic [7:0] b;
    b = 8'(8'h11 * (r + 1));
    return {(VLEN/8){b}};
  endfunction

  // ---------------- stimulus ----------------
  logic [VLEN-1:0] a5s, x1, x2, r4_val;
  logic [VLEN/8-1:0] ones;
  int done_at;
  int done_cnt;

  initial begin
    a5s    = {(VLEN/8){8'hA5}};
    x1     = {(VLEN/32){32'hDEAD_BEEF}};
    x2     = {(VLEN/16){16'hC0DE}};
    ones   = '1;
    r4_val = {x2[VLEN-1:8], 8'h77};

    bus.RE = '0; bus.RA = '0; bus.WE = 1'b0; bus.WA = '0; bus.WMASK = '0;
    bus.WD = '0; bus.RSV_EN = 1'b0; bus.RSV_A = '0; bus.CLR_REQ = 1'b0;

    repeat (2) @(posedge CLK);
    #1;
    check("reset_rd0",      W'(bus.RD[0 +: VLEN]), W'(0));
    check("reset_rd1",      W'(bus.RD[VLEN +: VLEN]), W'(0));
    check("reset_rvalid",   W'(bus.RVALID), W'(0));
    check("reset_rbusy",    W'(bus.RBUSY), W'(0));
    check("reset_clr_busy", W'(bus.CLR_BUSY), W'(0));
    check("reset_clr_done", W'(bus.CLR_DONE), W'(0));
    check("reset_state",    W'(dbg_state), W'(IDLE));
    RST = 1'b1;

    // Read of a freshly reset register.
    set_read(0, 5'd3, '0, 1'b0); tick();

    // Full write then read back.
    set_write(5'd2, ones, a5s); tick();
    set_read(0, 5'd2, a5s, 1'b0); tick();

    // Single-byte masked write.
    set_write(5'd2, 32'h0000_0001, 256'hFF); tick();
    set_read(0, 5'd2, {a5s[VLEN-1:8], 8'hFF}, 1'b0); tick();

    // Same-cycle write/read bypass on port 1.
    set_write(5'd5, ones, 256'h1234); set_read(1, 5'd5, 256'h1234, 1'b0); tick();

    // Reservation, retire by write, simultaneous reserve+write.
    set_rsv(5'd4); tick();
    set_read(0, 5'd4, '0, 1'b1); tick();
    set_write(5'd4, ones, x1); tick();
    set_read(0, 5'd4, x1, 1'b0); tick();
    set_rsv(5'd4); set_write(5'd4, ones, x2); tick();
    set_read(0, 5'd4, x2, 1'b1); tick();
    // Bypass of a masked write plus reserve on the same edge.
    set_rsv(5'd4); set_write(5'd4, 32'h0000_0001, 256'h77);
    set_read(1, 5'd4, r4_val, 1'b1); tick();

    // Out-of-range write/read/reserve must not alias onto low registers.
    set_write(5'd20, ones, '1); set_read(1, 5'd20, '0, 1'b0); set_rsv(5'd13); tick();
    set_read(0, 5'd4, r4_val, 1'b1); set_read(1, 5'd5, 256'h1234, 1'b0); tick();

    // Zero mask: data unchanged, reservation retired.
    set_write(5'd4, '0, '1); tick();
    set_read(0, 5'd4, r4_val, 1'b0); tick();

    // Preload every register and reserve one.
    for (int r = 0; r < NREGS; r++) begin
      set_write(5'(r), ones, pat(r)); tick();
    end
    set_rsv(5'd3); tick();
    set_read(0, 5'd7, pat(7), 1'b0); set_read(1, 5'd3, pat(3), 1'b1); tick();

    // Clear sequence with a dropped write and a read while busy.
    bus.CLR_REQ = 1'b1; tick();
    check("clr_busy_after_req", W'(bus.CLR_BUSY), W'(1));
    check("state_clear",        W'(dbg_state), W'(CLEAR));
    done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) set_write(5'd0, ones, '1);
      if (k == 4) set_read(0, 5'd7, '0, 1'b0);
      tick();
      if (bus.CLR_DONE) begin
        done_at = k;
        break;
      end
    end
    check("clr_done_latency", W'(done_at), W'(NREGS + 1));
    check("clr_busy_at_done", W'(bus.CLR_BUSY), W'(0));
    set_read(0, 5'd0, '0, 1'b0); set_read(1, 5'd3, '0, 1'b0); tick();
    check("clr_done_one_cycle", W'(bus.CLR_DONE), W'(0));
    set_read(0, 5'd7, '0, 1'b0); set_read(1, 5'd5, '0, 1'b0); tick();

    // Reset in the middle of a clear aborts it.
    set_write(5'd7, ones, x2); tick();
    bus.CLR_REQ = 1'b1; tick();
    tick(); tick();
    check("clr_busy_mid_clear", W'(bus.CLR_BUSY), W'(1));
    RST = 1'b0;
    #2;
    check("clr_busy_async_reset", W'(bus.CLR_BUSY), W'(0));
    check("state_async_reset",    W'(dbg_state), W'(IDLE));
    RST = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.CLR_DONE) done_cnt++;
    end
    check("no_done_after_abort", W'(done_cnt), W'(0));
    set_read(0, 5'd7, '0, 1'b0); tick();
    set_write(5'd6, ones, x1); tick();
    set_read(1, 5'd6, x1, 1'b0); tick();
    tick(); tick();

    check("q0_drained", W'(exp_q0.size()), W'(0));
    check("q1_drained", W'(exp_q1.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
